// File: rtl/ahb_lite_pkg.sv
// ahb_lite_pkg: shared AHB-Lite transfer encodings and the command record carried through the master pipeline
package ahb_lite_pkg;
   typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11} htrans_t;
   localparam logic [2:0] HSIZE_WORD = 3'b010;
   localparam int CMD_ADDR_W = 32;
   localparam int CMD_DATA_W = 32;
   typedef struct packed {
      logic                  write;
      logic [CMD_ADDR_W-1:0] addr;
      logic [CMD_DATA_W-1:0] wdata;
   } ahb_cmd_t;
endpackage

// File: rtl/ahb_cmd_fifo.sv
// ahb_cmd_fifo: synchronous command FIFO with wrap-bit pointers for full/empty
module ahb_cmd_fifo
   import ahb_lite_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic     clk,
   input  logic     rst_n,
   input  logic     push,
   input  logic     pop,
   input  ahb_cmd_t din,
   output ahb_cmd_t dout,
   output logic     full,
   output logic     empty
);
   localparam int AW = $clog2(DEPTH);
   ahb_cmd_t mem [DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;
   assign empty   = wr_ptr == rd_ptr;
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr[AW-1:0]];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end
endmodule

// File: rtl/ahb_lite_cmd_master.sv
// ahb_lite_cmd_master: turns a valid/ready command stream into pipelined single NONSEQ AHB-Lite word transfers
module ahb_lite_cmd_master
   import ahb_lite_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 256
)(
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              busy,
   output logic              err_timeout,
   output logic              HSEL,
   output logic [ADDR_W-1:0] HADDR,
   output logic [1:0]        HTRANS,
   output logic              HWRITE,
   output logic [2:0]        HSIZE,
   output logic [DATA_W-1:0] HWDATA,
   input  logic              HREADY,
   input  logic [DATA_W-1:0] HRDATA
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   ahb_cmd_t din, head, ap;
   logic ap_valid, dp_valid, dp_write, full, empty, pop;
   logic [CNT_W-1:0] stall_cnt;
   always_comb begin
      din       = '0;
      din.write = cmd_write;
      din.addr  = CMD_ADDR_W'(cmd_addr & ~ADDR_W'(3));
      din.wdata = CMD_DATA_W'(cmd_wdata);
   end
   assign pop       = HREADY && !empty;
   assign cmd_ready = !full;
   assign busy      = !empty || ap_valid || dp_valid;
   assign HSEL      = ap_valid;
   assign HTRANS    = ap_valid ? NONSEQ : IDLE;
   assign HADDR     = ADDR_W'(ap.addr);
   assign HWRITE    = ap.write;
   assign HSIZE     = HSIZE_WORD;
   ahb_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (HCLK),
      .rst_n (HRESETn),
      .push  (cmd_valid && cmd_ready),
      .pop   (pop),
      .din   (din),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         ap          <= '0;
         ap_valid    <= 1'b0;
         dp_valid    <= 1'b0;
         dp_write    <= 1'b0;
         HWDATA      <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         stall_cnt   <= '0;
         err_timeout <= 1'b0;
      end else begin
         rsp_valid <= HREADY && dp_valid && !dp_write;
         if (HREADY) begin
            if (dp_valid && !dp_write) rsp_rdata <= HRDATA;
            dp_valid <= ap_valid;
            dp_write <= ap.write;
            if (ap_valid && ap.write) HWDATA <= DATA_W'(ap.wdata);
            ap_valid <= !empty;
            if (!empty) ap <= head;
         end
         // counter saturates at TIMEOUT; the stalled transfer is left to finish
         if (HREADY) stall_cnt <= '0;
         else if (dp_valid && stall_cnt != CNT_W'(TIMEOUT)) stall_cnt <= stall_cnt + 1'b1;
         if (dp_valid && !HREADY && stall_cnt == CNT_W'(TIMEOUT - 1)) err_timeout <= 1'b1;
      end
   end
endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// tb_ahb_lite_cmd_master: scenario tasks plus a transfer/response scoreboard sampled at the falling edge
module tb_ahb_lite_cmd_master;
   localparam logic [1:0] NS = 2'b10;
   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        cmd_valid, cmd_write, cmd_ready;
   logic [31:0] cmd_addr, cmd_wdata;
   logic        rsp_valid, busy, err_timeout, HSEL, HWRITE, HREADY;
   logic [31:0] rsp_rdata, HADDR, HWDATA, HRDATA;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE;
   int checks = 0;
   int failures = 0;
   logic [31:0] exp_addr_q[$];
   logic        exp_write_q[$];
   logic [31:0] exp_wdata_q[$];
   logic [31:0] rsp_q[$];
   bit          dp_on = 0;
   logic        dp_wr;
   logic [31:0] dp_wd;
   bit          last_acc;

   always #5 HCLK = ~HCLK;

   ahb_lite_cmd_master dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy), .err_timeout(err_timeout),
      .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
      .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA)
   );

   // one clock: scoreboard work at the falling edge, then return just after the rising edge
   task automatic tick();
      logic [31:0] a, d, r;
      logic w;
      @(negedge HCLK);
      last_acc = cmd_valid && cmd_ready;
      if (last_acc) begin
         exp_addr_q.push_back(cmd_addr & 32'hFFFF_FFFC);
         exp_write_q.push_back(cmd_write);
         exp_wdata_q.push_back(cmd_wdata);
      end
      if (rsp_valid) begin
         checks++;
         if (rsp_q.size() == 0) begin failures++; $display("FAIL sb_rsp unexpected rsp_rdata=%h", rsp_rdata); end
         else begin
            r = rsp_q.pop_front();
            if (rsp_rdata !== r) begin failures++; $display("FAIL sb_rsp got=%h exp=%h", rsp_rdata, r); end
         end
      end
      if (HREADY === 1'b1) begin
         if (dp_on && dp_wr) begin
            checks++;
            if (HWDATA !== dp_wd) begin failures++; $display("FAIL sb_hwdata got=%h exp=%h", HWDATA, dp_wd); end
         end else if (dp_on) rsp_q.push_back(HRDATA);
         dp_on = 0;
         if (HTRANS === NS) begin
            checks++;
            if (exp_addr_q.size() == 0) begin failures++; $display("FAIL sb_xfer unexpected HADDR=%h", HADDR); end
            else begin
               a = exp_addr_q.pop_front(); w = exp_write_q.pop_front(); d = exp_wdata_q.pop_front();
               if (HADDR !== a || HWRITE !== w) begin
                  failures++; $display("FAIL sb_addr got=%h/%b exp=%h/%b", HADDR, HWRITE, a, w);
               end
               dp_on = 1; dp_wr = w; dp_wd = d;
            end
         end
      end
      @(posedge HCLK); #1;
   endtask

   task automatic set_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
   endtask

   task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d);
      set_cmd(w, a, d);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic drain();
      for (int n = 0; n < 30 && busy; n++) tick();
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL drain busy got=%b exp=0", busy); end
   endtask

   task automatic test_reset();
      checks += 10;
      if (HTRANS !== 2'b00) begin failures++; $display("FAIL rst_htrans got=%b exp=00", HTRANS); end
      if (HSEL !== 1'b0) begin failures++; $display("FAIL rst_hsel got=%b exp=0", HSEL); end
      if (HADDR !== 32'h0) begin failures++; $display("FAIL rst_haddr got=%h exp=0", HADDR); end
      if (HWRITE !== 1'b0) begin failures++; $display("FAIL rst_hwrite got=%b exp=0", HWRITE); end
      if (HWDATA !== 32'h0) begin failures++; $display("FAIL rst_hwdata got=%h exp=0", HWDATA); end
      if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin failures++; $display("FAIL rst_rsp got=%b/%h exp=0/0", rsp_valid, rsp_rdata); end
      if (err_timeout !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", err_timeout); end
      if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
      if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_cmd_ready got=%b exp=1", cmd_ready); end
      if (HSIZE !== 3'b010) begin failures++; $display("FAIL rst_hsize got=%b exp=010", HSIZE); end
   endtask

   task automatic test_single_write();
      push(1'b1, 32'h5000_0000, 32'h0000_0041);
      checks++;
      if (HTRANS !== 2'b00) begin failures++; $display("FAIL sw_pre_idle got=%b exp=00", HTRANS); end
      tick();
      checks += 2;
      if (HTRANS !== NS || HSEL !== 1'b1) begin failures++; $display("FAIL sw_nonseq got=%b/%b exp=10/1", HTRANS, HSEL); end
      if (HWRITE !== 1'b1 || HADDR !== 32'h5000_0000) begin failures++; $display("FAIL sw_addr got=%b/%h exp=1/50000000", HWRITE, HADDR); end
      tick();
      checks += 2;
      if (HTRANS !== 2'b00 || HSEL !== 1'b0) begin failures++; $display("FAIL sw_post_idle got=%b/%b exp=00/0", HTRANS, HSEL); end
      if (HWDATA !== 32'h41 || busy !== 1'b1) begin failures++; $display("FAIL sw_data got=%h/%b exp=41/1", HWDATA, busy); end
      tick();
      checks++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0) begin failures++; $display("FAIL sw_done got=%b/%b exp=0/0", busy, rsp_valid); end
   endtask

   task automatic test_back_to_back();
      logic [1:0]  rt[12];
      logic [31:0] ra[12], rd[12];
      int first = -1;
      for (int k = 0; k < 12; k++) begin
         if (k < 3) set_cmd(1'b1, 32'(4 * k), 32'(8'h11 * (k + 1)));
         else cmd_valid = 1'b0;
         tick();
         rt[k] = HTRANS; ra[k] = HADDR; rd[k] = HWDATA;
      end
      for (int k = 11; k >= 0; k--) if (rt[k] === NS) first = k;
      checks++;
      if (first != 1) begin failures++; $display("FAIL b2b_latency got=%0d exp=1", first); end
      if (first >= 0 && first < 8) begin
         for (int j = 0; j < 3; j++) begin
            checks += 2;
            if (rt[first+j] !== NS || ra[first+j] !== 32'(4 * j)) begin
               failures++; $display("FAIL b2b_addr%0d got=%b/%h exp=10/%h", j, rt[first+j], ra[first+j], 32'(4 * j));
            end
            if (rd[first+j+1] !== 32'(8'h11 * (j + 1))) begin
               failures++; $display("FAIL b2b_data%0d got=%h exp=%h", j, rd[first+j+1], 32'(8'h11 * (j + 1)));
            end
         end
         checks++;
         if (rt[first+3] !== 2'b00) begin failures++; $display("FAIL b2b_end got=%b exp=00", rt[first+3]); end
      end
      drain();
   endtask

   task automatic test_read_stall();
      push(1'b0, 32'h5000_0004, 32'h0);
      push(1'b1, 32'h5000_0008, 32'h77);
      checks++;
      if (HTRANS !== NS || HADDR !== 32'h5000_0004 || HWRITE !== 1'b0) begin
         failures++; $display("FAIL rd_addr got=%b/%h/%b exp=10/50000004/0", HTRANS, HADDR, HWRITE);
      end
      tick();
      HREADY = 1'b0; HRDATA = 32'h0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (HTRANS !== NS || HADDR !== 32'h5000_0008 || HWRITE !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++; $display("FAIL rd_hold%0d got=%b/%h/%b/%b exp=10/50000008/1/0", i, HTRANS, HADDR, HWRITE, rsp_valid);
         end
      end
      HREADY = 1'b1; HRDATA = 32'hDEAD_BEEF;
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF) begin
         failures++; $display("FAIL rd_rsp got=%b/%h exp=1/deadbeef", rsp_valid, rsp_rdata);
      end
      HRDATA = 32'h0;
      tick();
      checks++;
      if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rd_pulse got=%b exp=0", rsp_valid); end
      drain();
   endtask

   task automatic test_fifo_full();
      int acc = 0;
      push(1'b1, 32'h100, 32'hA0);
      tick();
      HREADY = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         set_cmd(1'b1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
         tick();
         if (last_acc) acc++;
      end
      checks += 2;
      if (acc != 4) begin failures++; $display("FAIL ff_accepts got=%0d exp=4", acc); end
      if (cmd_ready !== 1'b0) begin failures++; $display("FAIL ff_ready got=%b exp=0", cmd_ready); end
      HREADY = 1'b1;
      last_acc = 0;
      for (int n = 0; n < 10 && !last_acc; n++) tick();
      cmd_valid = 1'b0;
      checks++;
      if (!last_acc) begin failures++; $display("FAIL ff_resume got=0 exp=1"); end
      drain();
      checks++;
      if (exp_addr_q.size() != 0) begin failures++; $display("FAIL ff_order left=%0d exp=0", exp_addr_q.size()); end
   endtask

   task automatic test_unaligned();
      push(1'b1, 32'h0000_1237, 32'h5A);
      tick();
      checks++;
      if (HTRANS !== NS || HADDR !== 32'h0000_1234) begin failures++; $display("FAIL ua_haddr got=%b/%h exp=10/00001234", HTRANS, HADDR); end
      drain();
   endtask

   task automatic test_timeout();
      push(1'b1, 32'h5000_0010, 32'hC3);
      tick();
      tick();
      HREADY = 1'b0;
      repeat (255) tick();
      checks++;
      if (err_timeout !== 1'b0) begin failures++; $display("FAIL to_early got=%b exp=0", err_timeout); end
      tick();
      checks++;
      if (err_timeout !== 1'b1) begin failures++; $display("FAIL to_set got=%b exp=1", err_timeout); end
      repeat (44) tick();
      checks++;
      if (HWDATA !== 32'hC3 || busy !== 1'b1) begin failures++; $display("FAIL to_hold got=%h/%b exp=c3/1", HWDATA, busy); end
      HREADY = 1'b1;
      tick();
      checks += 2;
      if (err_timeout !== 1'b1) begin failures++; $display("FAIL to_sticky got=%b exp=1", err_timeout); end
      if (busy !== 1'b0) begin failures++; $display("FAIL to_complete got=%b exp=0", busy); end
   endtask

   task automatic test_reset_mid();
      int bad = 0;
      push(1'b0, 32'h5000_0020, 32'h0);
      tick();
      tick();
      HREADY = 1'b0; HRDATA = 32'h1234_5678;
      push(1'b1, 32'h5000_0024, 32'h1);
      HRESETn = 1'b0;
      #1;
      checks += 3;
      if (HTRANS !== 2'b00 || HSEL !== 1'b0) begin failures++; $display("FAIL rm_idle got=%b/%b exp=00/0", HTRANS, HSEL); end
      if (busy !== 1'b0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL rm_flush got=%b/%b exp=0/1", busy, cmd_ready); end
      if (err_timeout !== 1'b0) begin failures++; $display("FAIL rm_err got=%b exp=0", err_timeout); end
      exp_addr_q.delete(); exp_write_q.delete(); exp_wdata_q.delete(); rsp_q.delete(); dp_on = 0;
      repeat (2) @(posedge HCLK);
      #1 HRESETn = 1'b1; HREADY = 1'b1;
      for (int n = 0; n < 8; n++) begin
         tick();
         if (rsp_valid !== 1'b0 || HTRANS !== 2'b00) bad++;
      end
      checks++;
      if (bad != 0) begin failures++; $display("FAIL rm_quiet got=%0d exp=0", bad); end
   endtask

   initial begin
      HRESETn = 1'b0; HREADY = 1'b1; HRDATA = 32'h0;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
      repeat (3) @(posedge HCLK);
      #1 HRESETn = 1'b1;
      test_reset();
      test_single_write();
      test_back_to_back();
      test_read_stall();
      test_fifo_full();
      test_unaligned();
      test_timeout();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
